flight_frame_uart_tx: RTL and testbench
=======================================

// Module: flight_frame_uart_tx
// PURPOSE
//  Downstream drain of the subframe RAM. On a start edge it reads WORDS 32-bit words via rd_FLIGHT/FLIGHT_out.
//  It sends them on a single 8N1 UART line: byte order [7:0],[15:8],[23:16],[31:24], bits LSB first.
//  The byte stream is gap-free (stop bit of byte n is followed directly by the start bit of byte n+1).
//  Sits between the subframe RAM read port and the board serial/telemetry pin.
// PARAMETERS
//  CLK_DIV   434  clocks per UART bit (50 MHz / 115200); legal range 4..4095
//  WORDS     48   32-bit words per frame (96 16-bit subframe entries); legal range 1..256
//  RD_LAT    1    clocks from rd_FLIGHT change to valid FLIGHT_out; legal range 1..3
// PORTS
//  clock       in   1   system clock, all logic on posedge
//  reset       in   1   asynchronous, active-high
//  start       in   1   level; a rising edge (0->1, registered) requests transmission of one frame
//  rd_FLIGHT   out  8   RAM read address, registered
//  FLIGHT_out  in   32  RAM read data, valid RD_LAT clocks after address
//  tx          out  1   UART line, idle high
//  busy        out  1   high from accepted start edge until the last stop bit completes
//  done        out  1   one-clock pulse in the cycle after the last stop bit ends
//  overrun     out  1   one-clock pulse when a start edge arrives while busy (request dropped)
// BEHAVIOUR
//  Reset (async, any state): tx=1, busy=0, done=0, overrun=0, rd_FLIGHT=0, counters=0, FSM=IDLE.
//   Any in-flight byte is abandoned mid-bit; the line returns high immediately.
//  Edge detect: start_q <= start; edge = start & ~start_q. start_q resets to 0, so start held high through reset
//   gives one edge in the first cycle after release.
//  FSM states:
//   IDLE: rd_FLIGHT=0. On edge: busy<=1 -> FETCH.
//   FETCH: wait RD_LAT clocks with a lat counter, then word_buf<=FLIGHT_out, rd_FLIGHT<=rd_FLIGHT+1 -> LOAD.
//   LOAD: shifter <= current byte of word_buf (byte_idx 0..3), start uart_byte_tx -> SEND.
//   SEND: wait for byte_done.
//    If byte_idx<3: byte_idx++ -> LOAD.
//    If byte_idx==3 and word_cnt<WORDS-1: word_cnt++, byte_idx=0, word_buf<=prefetch -> LOAD.
//    If the last word is done -> FINISH.
//   FINISH: busy<=0, done<=1 for one clock, rd_FLIGHT<=0 -> IDLE.
//  Prefetch: the next word is read while byte 0 of the current word is in flight. Its RD_LAT latency is hidden
//   because RD_LAT << 10*CLK_DIV. This makes LOAD for the next word immediate, so there are no inter-byte gaps.
//  Address arithmetic: 8-bit, not wrapping within a frame (WORDS<=256). Word 0 is read at address 0.
//  LOAD for the next byte happens in the same clock as byte_done, so the new start bit begins on the next clock.
//  Frame duration: WORDS*4*10*CLK_DIV clocks from the first start-bit clock to the end of the last stop bit.
//  Start edge while busy: ignored for data, overrun pulses 1 clock, transmission unaffected.
//  Start edge in the same clock as done: counts as busy -> overrun. busy drops the clock after done.
//  FLIGHT_out is sampled only at the end of each FETCH latency window. The RAM may be rewritten outside that
//   window; the upstream stage guarantees no writes while busy.
// STRUCTURE
//  Shared include flight_defs.vh:
//   UART_IDLE=1'b1, UART_START=1'b0, UART_STOP=1'b1, FLIGHT_WORDS=48, SYNC_WORD=16'hFF7F.
//  Sub-module uart_byte_tx (CLK_DIV):
//   ports: clock, reset, load, data[7:0] -> tx, byte_done.
//   10-bit shift register and a 12-bit bit-timer; byte_done pulses on the last clock of the stop bit.
//  Top level: edge detect, frame FSM, address/word/byte counters, word_buf, prefetch register, latency counter.
// TESTING
//  Use CLK_DIV=4 and a RAM model with RD_LAT=1, preloaded word0=32'h0001_FF7F, word1=32'hA5A5_5A5A.
//  Single frame, WORDS=2:
//   Expected bytes: 7F FF 01 00 5A 5A A5 A5. Each bit is 4 clocks; busy lasts 320 clocks plus the fetch.
//   done pulses once, rd_FLIGHT ends at 0.
//  Gap-free check:
//   For every pair of adjacent bytes, the start bit falls exactly 1 clock after the stop bit ends.
//  Overrun:
//   Pulse start again mid-frame -> overrun=1 for 1 clock, byte stream identical to the single-frame case,
//   done pulses once only.
//  Reset mid-byte:
//   Assert reset during bit 3 of byte 2 -> tx=1, busy=0 in the same cycle.
//   A start after release sends the full frame from word 0.
//  RD_LAT=3, WORDS=48:
//   Output bytes match the RAM contents 0..47 in order. rd_FLIGHT never exceeds 48.
//   Frame length is exactly 1920*CLK_DIV clocks.
//  Start held high across reset release:
//   Exactly one frame is sent, with no second frame until start goes 0->1 again.

Source files
------------

// File: rtl/flight_frame_uart_tx_pkg.sv
// Shared constants, FSM state type and byte-select helper
// for the flight frame UART drain.
package flight_frame_uart_tx_pkg;

  localparam logic UART_IDLE    = 1'b1;
  localparam logic UART_START   = 1'b0;
  localparam logic UART_STOP    = 1'b1;
  localparam int   FLIGHT_WORDS = 48;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_SEND,
    S_FINISH
  } frame_state_t;

  function automatic logic [7:0] word_byte(
    input logic [31:0] w,
    input logic [1:0]  idx
  );
    unique case (idx)
      2'd0:    word_byte = w[7:0];
      2'd1:    word_byte = w[15:8];
      2'd2:    word_byte = w[23:16];
      default: word_byte = w[31:24];
    endcase
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serializer. A load on the last stop-bit clock
// chains the next byte with no idle gap.
module uart_byte_tx
  import flight_frame_uart_tx_pkg::*;
#(
  parameter int CLK_DIV = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       byte_done
);

  localparam logic [11:0] LAST_TICK = 12'(CLK_DIV - 1);

  logic [9:0]  r_shift;
  logic [11:0] r_timer;
  logic [3:0]  r_bits;
  logic        r_active;
  logic        w_tick;

  assign w_tick    = (r_timer == LAST_TICK);
  assign byte_done = r_active & w_tick & (r_bits == 4'd9);
  assign tx        = r_shift[0];

  // Bit timer and LSB-first shift register; idle fill is ones.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_shift  <= {10{UART_IDLE}};
      r_timer  <= '0;
      r_bits   <= '0;
      r_active <= 1'b0;
    end else if (load) begin
      r_shift  <= {UART_STOP, data, UART_START};
      r_timer  <= '0;
      r_bits   <= '0;
      r_active <= 1'b1;
    end else if (r_active) begin
      if (w_tick) begin
        r_timer <= '0;
        r_shift <= {UART_IDLE, r_shift[9:1]};
        if (r_bits == 4'd9) begin
          r_bits   <= '0;
          r_active <= 1'b0;
        end else begin
          r_bits <= r_bits + 4'd1;
        end
      end else begin
        r_timer <= r_timer + 12'd1;
      end
    end
  end

endmodule

// File: rtl/flight_frame_uart_tx.sv
// Drains WORDS 32-bit words from the subframe RAM onto
// one gap-free 8N1 line, prefetching the next word.
module flight_frame_uart_tx
  import flight_frame_uart_tx_pkg::*;
#(
  parameter int CLK_DIV = 434,
  parameter int WORDS   = FLIGHT_WORDS,
  parameter int RD_LAT  = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic [7:0]  rd_FLIGHT,
  input  logic [31:0] FLIGHT_out,
  output logic        tx,
  output logic        busy,
  output logic        done,
  output logic        overrun
);

  localparam logic [1:0] LAT       = 2'(RD_LAT);
  localparam logic [7:0] LAST_WORD = 8'(WORDS - 1);

  frame_state_t r_state;
  logic        r_start_q;
  logic [7:0]  r_rd;
  logic [31:0] r_word_buf;
  logic [31:0] r_prefetch;
  logic [1:0]  r_lat;
  logic [1:0]  r_pf_lat;
  logic        r_pf_pend;
  logic [1:0]  r_byte_idx;
  logic [7:0]  r_word_cnt;
  logic        r_busy;
  logic        r_done;
  logic        r_overrun;

  logic        w_edge;
  logic        w_byte_done;
  logic        w_last_byte;
  logic        w_last_word;
  logic        w_fetch_done;
  logic        w_word_next;
  logic        w_load;
  logic [7:0]  w_data;

  assign w_edge       = start & ~r_start_q;
  assign w_last_byte  = (r_byte_idx == 2'd3);
  assign w_last_word  = (r_word_cnt == LAST_WORD);
  assign w_fetch_done = (r_state == S_FETCH) & (r_lat == LAT);
  assign w_word_next  = (r_state == S_SEND) & w_byte_done
                      & w_last_byte & ~w_last_word;

  assign rd_FLIGHT = r_rd;
  assign busy      = r_busy;
  assign done      = r_done;
  assign overrun   = r_overrun;

  // Next byte is handed over in the byte_done clock itself.
  always_comb begin
    w_load = 1'b0;
    w_data = word_byte(r_word_buf, r_byte_idx);
    if (r_state == S_LOAD) begin
      w_load = 1'b1;
    end else if (r_state == S_SEND && w_byte_done) begin
      if (!w_last_byte) begin
        w_load = 1'b1;
        w_data = word_byte(r_word_buf, r_byte_idx + 2'd1);
      end else if (!w_last_word) begin
        w_load = 1'b1;
        w_data = r_prefetch[7:0];
      end
    end
  end

  // Frame FSM with counters and registered status outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_start_q  <= 1'b0;
      r_rd       <= '0;
      r_word_buf <= '0;
      r_lat      <= '0;
      r_byte_idx <= '0;
      r_word_cnt <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_start_q <= start;
      r_done    <= 1'b0;
      r_overrun <= w_edge & r_busy;
      case (r_state)
        S_IDLE: begin
          r_rd <= '0;
          if (w_edge) begin
            r_busy     <= 1'b1;
            r_lat      <= '0;
            r_byte_idx <= '0;
            r_word_cnt <= '0;
            r_state    <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (w_fetch_done) begin
            r_word_buf <= FLIGHT_out;
            r_rd       <= r_rd + 8'd1;
            r_state    <= S_LOAD;
          end else begin
            r_lat <= r_lat + 2'd1;
          end
        end
        S_LOAD: begin
          r_state <= S_SEND;
        end
        S_SEND: begin
          if (w_byte_done) begin
            if (!w_last_byte) begin
              r_byte_idx <= r_byte_idx + 2'd1;
            end else if (w_word_next) begin
              r_word_cnt <= r_word_cnt + 8'd1;
              r_byte_idx <= '0;
              r_word_buf <= r_prefetch;
              r_rd       <= r_rd + 8'd1;
            end else begin
              r_done  <= 1'b1;
              r_state <= S_FINISH;
            end
          end
        end
        S_FINISH: begin
          r_busy  <= 1'b0;
          r_rd    <= '0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Capture the word at the new address once its latency elapses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_prefetch <= '0;
      r_pf_lat   <= '0;
      r_pf_pend  <= 1'b0;
    end else if (r_pf_pend) begin
      if (r_pf_lat == LAT) begin
        r_prefetch <= FLIGHT_out;
        r_pf_pend  <= 1'b0;
        r_pf_lat   <= '0;
      end else begin
        r_pf_lat <= r_pf_lat + 2'd1;
      end
    end else if (w_fetch_done || w_word_next) begin
      r_pf_pend <= 1'b1;
      r_pf_lat  <= '0;
    end
  end

  uart_byte_tx #(
    .CLK_DIV(CLK_DIV)
  ) u_byte (
    .clock    (clock),
    .reset    (reset),
    .load     (w_load),
    .data     (w_data),
    .tx       (tx),
    .byte_done(w_byte_done)
  );

endmodule

// File: tb/tb_flight_frame_uart_tx.sv
// Bench for flight_frame_uart_tx: a 2-word and a 48-word
// instance, line decoded back into bytes and timing.
module tb_flight_frame_uart_tx;

  localparam int DIV = 4;

  typedef struct {
    logic [31:0] w0;
    logic [31:0] w1;
    logic [63:0] exp;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic [7:0]  rd_a, rd_b;
  logic [31:0] fo_a, fo_b, p1_b, p2_b;
  logic        tx_a, busy_a, done_a, ovr_a;
  logic        tx_b, busy_b, done_b, ovr_b;
  logic [31:0] mem_a [0:255];
  logic [31:0] mem_b [0:255];

  logic        q_tx[$];
  logic        q_busy[$];
  logic        q_done[$];
  logic        q_ovr[$];
  logic [7:0]  exp_bytes[$];
  int          rd_max;
  logic [7:0]  rd_last;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  always @(posedge clock) fo_a <= mem_a[rd_a];

  always @(posedge clock) begin
    p1_b <= mem_b[rd_b];
    p2_b <= p1_b;
    fo_b <= p2_b;
  end

  flight_frame_uart_tx #(.CLK_DIV(DIV), .WORDS(2), .RD_LAT(1)) dut_a (
    .clock(clock), .reset(reset), .start(start_a),
    .rd_FLIGHT(rd_a), .FLIGHT_out(fo_a), .tx(tx_a),
    .busy(busy_a), .done(done_a), .overrun(ovr_a)
  );

  flight_frame_uart_tx #(.CLK_DIV(DIV), .WORDS(48), .RD_LAT(3)) dut_b (
    .clock(clock), .reset(reset), .start(start_b),
    .rd_FLIGHT(rd_b), .FLIGHT_out(fo_b), .tx(tx_b),
    .busy(busy_b), .done(done_b), .overrun(ovr_b)
  );

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic set_start(input bit sel, input logic v);
    if (sel) start_b = v;
    else start_a = v;
  endtask

  function automatic logic smp(input int i);
    if (i >= 0 && i < q_tx.size()) return q_tx[i];
    return 1'b1;
  endfunction

  // Expected byte stream from RAM words: little-endian bytes.
  task automatic model_bytes(input bit sel, input int nwords);
    logic [31:0] w;
    exp_bytes.delete();
    for (int i = 0; i < nwords; i++) begin
      w = sel ? mem_b[i] : mem_a[i];
      for (int k = 0; k < 4; k++)
        exp_bytes.push_back(8'((w >> (8 * k)) & 32'hFF));
    end
  endtask

  // mode 0: one start pulse; 1: extra pulse at cycle p;
  // 2: extra pulse in the done cycle; 3: start untouched.
  task automatic capture(input bit sel, input int ncyc,
                         input int mode, input int p);
    int   hold;
    logic d;
    logic [7:0] r;
    q_tx.delete(); q_busy.delete();
    q_done.delete(); q_ovr.delete();
    rd_max = 0;
    hold = 0;
    r = '0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clock);
      q_tx.push_back(sel ? tx_b : tx_a);
      q_busy.push_back(sel ? busy_b : busy_a);
      d = sel ? done_b : done_a;
      q_done.push_back(d);
      q_ovr.push_back(sel ? ovr_b : ovr_a);
      r = sel ? rd_b : rd_a;
      if (int'(r) > rd_max) rd_max = int'(r);
      if (mode != 3) begin
        if (i == 0 || (mode == 1 && i == p) || (mode == 2 && d === 1'b1)) begin
          set_start(sel, 1'b1);
          hold = 2;
        end else if (hold > 0) begin
          hold--;
          if (hold == 0) set_start(sel, 1'b0);
        end
      end
    end
    rd_last = r;
  endtask

  task automatic analyze(input string tag, input int ovr_exp,
                         input int rd_lim);
    int s, pos, nxt, d_idx, ndone, novr, errs, extra, n;
    logic [7:0] b;
    logic bv;
    n = q_tx.size();
    s = -1;
    for (int i = 0; i < n; i++)
      if (s < 0 && q_tx[i] === 1'b0) s = i;
    check({tag, " start"}, 64'(s >= 0), 64'd1);
    if (s < 0) s = 0;
    pos = s;
    b = '0;
    for (int k = 0; k < exp_bytes.size(); k++) begin
      if (k > 0) begin
        nxt = pos;
        while (nxt < n && q_tx[nxt] !== 1'b0) nxt++;
        check($sformatf("%s gap%0d", tag, k), 64'(nxt - pos), 64'd0);
        pos = nxt;
      end
      errs = 0;
      for (int j = 0; j < 10; j++) begin
        bv = smp(pos + j * DIV);
        for (int m = 1; m < DIV; m++)
          if (smp(pos + j * DIV + m) !== bv) errs++;
        if (j >= 1 && j <= 8) b[j-1] = bv;
        if ((j == 0 && bv !== 1'b0) || (j == 9 && bv !== 1'b1)) errs++;
      end
      check($sformatf("%s byte%0d", tag, k), 64'(b), 64'(exp_bytes[k]));
      check($sformatf("%s framing%0d", tag, k), 64'(errs), 64'd0);
      pos += 10 * DIV;
    end
    d_idx = -1; ndone = 0; novr = 0; extra = 0;
    for (int i = 0; i < n; i++) begin
      if (q_done[i] === 1'b1) begin
        ndone++;
        if (d_idx < 0) d_idx = i;
      end
      if (q_ovr[i] === 1'b1) novr++;
      if (i >= pos && q_tx[i] !== 1'b1) extra++;
    end
    check({tag, " done count"}, 64'(ndone), 64'd1);
    check({tag, " frame len"}, 64'(d_idx - s),
          64'(exp_bytes.size() * 10 * DIV));
    check({tag, " overrun count"}, 64'(novr), 64'(ovr_exp));
    check({tag, " extra lows"}, 64'(extra), 64'd0);
    check({tag, " busy at start"}, 64'(q_busy[s]), 64'd1);
    check({tag, " busy at done"},
          64'((d_idx >= 0) ? q_busy[d_idx] : 1'b0), 64'd1);
    check({tag, " busy after done"},
          64'((d_idx >= 0 && d_idx + 1 < n) ? q_busy[d_idx+1] : 1'b1), 64'd0);
    check({tag, " rd max"}, 64'(rd_max <= rd_lim), 64'd1);
    check({tag, " rd end"}, 64'(rd_last), 64'd0);
  endtask

  initial begin
    vec_t vecs[3];
    int   t;
    vecs[0] = '{32'h0001_FF7F, 32'hA5A5_5A5A, 64'h7FFF_0100_5A5A_A5A5};
    vecs[1] = '{32'h0000_0000, 32'hFFFF_FFFF, 64'h0000_0000_FFFF_FFFF};
    vecs[2] = '{32'h1234_5678, 32'h8000_0001, 64'h7856_3412_0100_0080};
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 32'h0;
      mem_b[i] = $urandom;
    end

    #1 reset = 1'b1;
    #1;
    check("reset tx", 64'(tx_a), 64'd1);
    check("reset busy", 64'(busy_a), 64'd0);
    check("reset done", 64'(done_a), 64'd0);
    check("reset overrun", 64'(ovr_a), 64'd0);
    check("reset rd", 64'(rd_a), 64'd0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    for (int v = 0; v < 3; v++) begin
      mem_a[0] = vecs[v].w0;
      mem_a[1] = vecs[v].w1;
      exp_bytes.delete();
      for (int k = 0; k < 8; k++)
        exp_bytes.push_back(8'(vecs[v].exp >> (56 - 8 * k)));
      capture(1'b0, 400, 0, 0);
      analyze($sformatf("vec%0d", v), 0, 2);
    end

    for (int r = 0; r < 3; r++) begin
      mem_a[0] = $urandom;
      mem_a[1] = $urandom;
      model_bytes(1'b0, 2);
      capture(1'b0, 400, 0, 0);
      analyze($sformatf("rand%0d", r), 0, 2);
    end

    mem_a[0] = vecs[0].w0;
    mem_a[1] = vecs[0].w1;
    model_bytes(1'b0, 2);
    capture(1'b0, 400, 1, 100);
    analyze("ovr mid", 1, 2);
    capture(1'b0, 400, 2, 0);
    analyze("ovr at done", 1, 2);

    @(negedge clock);
    start_a = 1'b1;
    for (t = 0; t < 50; t++) begin
      @(negedge clock);
      if (t == 1) start_a = 1'b0;
      if (tx_a === 1'b0) break;
    end
    start_a = 1'b0;
    check("rst seq start", 64'(t < 50), 64'd1);
    repeat (2 * 10 * DIV + 4 * DIV + 1) @(negedge clock);
    check("pre-reset tx", 64'(tx_a), 64'd0);
    check("pre-reset busy", 64'(busy_a), 64'd1);
    reset = 1'b1;
    #1;
    check("mid-reset tx", 64'(tx_a), 64'd1);
    check("mid-reset busy", 64'(busy_a), 64'd0);
    check("mid-reset rd", 64'(rd_a), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    capture(1'b0, 400, 0, 0);
    analyze("after reset", 0, 2);

    reset = 1'b1;
    start_a = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    capture(1'b0, 800, 3, 0);
    analyze("held start", 0, 2);
    start_a = 1'b0;
    repeat (3) @(negedge clock);

    model_bytes(1'b1, 48);
    capture(1'b1, 48 * 40 * DIV + 120, 0, 0);
    analyze("w48", 0, 48);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
